// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Purpose  : Bundle of the producer handshakes (ALU path A, variable-latency
//             path M) and the register-file write port / status outputs of
//             regfile_wb_arbiter.
//  Ports    : slave  - arbiter side (consumes A/M, drives write port/status)
//             master - producer / register-file side
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    logic                     a_valid;
    logic                     a_ready;
    logic [4:0]               a_rd;
    logic [63:0]              a_data;
    logic                     m_valid;
    logic                     m_ready;
    logic [4:0]               m_rd;
    logic [63:0]              m_data;
    logic                     RegWr;
    logic [4:0]               RW;
    logic [63:0]              BusW;
    logic [31:0]              pending;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport slave (
        input  a_valid, a_rd, a_data, m_valid, m_rd, m_data,
        output a_ready, m_ready, RegWr, RW, BusW, pending, fifo_count
    );

    modport master (
        output a_valid, a_rd, a_data, m_valid, m_rd, m_data,
        input  a_ready, m_ready, RegWr, RW, BusW, pending, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Merges the ALU writeback path (A, priority) and the
//             variable-latency path (M, buffered in a DEPTH-entry FIFO) onto
//             the single register-file write port, and publishes a mask of
//             registers with writes still waiting in the FIFO.
//  Ports    : Clk    - clock, rising edge
//             resetl - synchronous active-low reset
//             bus    - regfile_wb_arbiter_if.slave (A/M handshakes,
//                      RegWr/RW/BusW, pending, fifo_count)
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 Clk,
    input  logic                 resetl,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]          rd_mem_q   [DEPTH];
    logic [63:0]         data_mem_q [DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]  count_q, count_d;
    logic [c_STV_W-1:0]  starve_q, starve_d;
    logic [31:0]         pending_q, pending_d;
    logic                regwr_q, regwr_d;
    logic [4:0]          rw_q, rw_d;
    logic [63:0]         busw_q, busw_d;

    logic w_fifo_empty, w_a_ready, w_m_ready;
    logic w_a_win, w_pop, w_m_keep, w_bypass, w_push;

    assign w_fifo_empty = (count_q == '0);
    // Once A has blocked a non-empty FIFO long enough, refuse A for one
    // cycle so the head is guaranteed a slot.
    assign w_a_ready    = resetl && !(!w_fifo_empty && (starve_q >= c_STV_W'(STARVE_LIMIT)));
    // Occupancy only: a full FIFO refuses M even in a cycle where it pops.
    assign w_m_ready    = resetl && (count_q < c_CNT_W'(DEPTH));

    // Writes to X31 are accepted but discarded, leaving the slot free.
    assign w_a_win  = bus.a_valid && w_a_ready && (bus.a_rd != 5'd31);
    assign w_pop    = !w_a_win && !w_fifo_empty;
    assign w_m_keep = bus.m_valid && w_m_ready && (bus.m_rd != 5'd31);
    assign w_bypass = w_m_keep && !w_a_win && w_fifo_empty;
    assign w_push   = w_m_keep && !w_bypass;

    always_comb begin
        logic [c_PTR_W-1:0] idx;
        logic [4:0]         ent_rd;

        regwr_d = 1'b0;
        rw_d    = 5'd0;
        busw_d  = 64'd0;
        if (w_a_win) begin
            regwr_d = 1'b1;
            rw_d    = bus.a_rd;
            busw_d  = bus.a_data;
        end else if (w_pop) begin
            regwr_d = 1'b1;
            rw_d    = rd_mem_q[rd_ptr_q];
            busw_d  = data_mem_q[rd_ptr_q];
        end else if (w_bypass) begin
            regwr_d = 1'b1;
            rw_d    = bus.m_rd;
            busw_d  = bus.m_data;
        end

        wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (w_push && !w_pop)
            count_d = count_q + 1'b1;
        else if (!w_push && w_pop)
            count_d = count_q - 1'b1;

        if (w_fifo_empty || w_pop)
            starve_d = '0;
        else if (w_a_win && (starve_q < c_STV_W'(STARVE_LIMIT)))
            starve_d = starve_q + 1'b1;
        else
            starve_d = starve_q;

        // Mask reflects the FIFO as it will be after this edge, including
        // the entry being pushed this cycle.
        pending_d = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx    = rd_ptr_d + c_PTR_W'(i);
            ent_rd = (w_push && (idx == wr_ptr_q)) ? bus.m_rd : rd_mem_q[idx];
            if (c_CNT_W'(i) < count_d)
                pending_d[ent_rd] = 1'b1;
        end
        pending_d[31] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!resetl) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            pending_q <= 32'd0;
            regwr_q   <= 1'b0;
            rw_q      <= 5'd0;
            busw_q    <= 64'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
            regwr_q   <= regwr_d;
            rw_q      <= rw_d;
            busw_q    <= busw_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers/count.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            rd_mem_q[wr_ptr_q]   <= bus.m_rd;
            data_mem_q[wr_ptr_q] <= bus.m_data;
        end
    end

    assign bus.a_ready    = w_a_ready;
    assign bus.m_ready    = w_m_ready;
    assign bus.RegWr      = regwr_q;
    assign bus.RW         = rw_q;
    assign bus.BusW       = busw_q;
    assign bus.pending    = pending_q;
    assign bus.fifo_count = count_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed self-checking bench for regfile_wb_arbiter
//             (DEPTH=4, STARVE_LIMIT=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    logic Clk = 1'b0;
    logic resetl = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    regfile_wb_arbiter_if #(.DEPTH(4)) bus ();

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .Clk    (Clk),
        .resetl (resetl),
        .bus    (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.a_valid = 1'b0; bus.a_rd = 5'd0; bus.a_data = 64'd0;
        bus.m_valid = 1'b0; bus.m_rd = 5'd0; bus.m_data = 64'd0;
    endtask

    task automatic test_reset();
        idle();
        bus.a_valid = 1'b1; bus.m_valid = 1'b1;
        resetl = 1'b0;
        tick(); tick();
        total_cnt++; if (bus.a_ready !== 1'b0) $display("FAIL rst_a_ready: got %0h exp 0", bus.a_ready); else pass_cnt++;
        total_cnt++; if (bus.m_ready !== 1'b0) $display("FAIL rst_m_ready: got %0h exp 0", bus.m_ready); else pass_cnt++;
        total_cnt++; if (bus.RegWr !== 1'b0) $display("FAIL rst_regwr: got %0h exp 0", bus.RegWr); else pass_cnt++;
        total_cnt++; if (bus.RW !== 5'd0) $display("FAIL rst_rw: got %0h exp 0", bus.RW); else pass_cnt++;
        total_cnt++; if (bus.BusW !== 64'd0) $display("FAIL rst_busw: got %0h exp 0", bus.BusW); else pass_cnt++;
        total_cnt++; if (bus.fifo_count !== 3'd0) $display("FAIL rst_count: got %0h exp 0", bus.fifo_count); else pass_cnt++;
        total_cnt++; if (bus.pending !== 32'd0) $display("FAIL rst_pending: got %0h exp 0", bus.pending); else pass_cnt++;
        idle();
        resetl = 1'b1;
        #1;
        total_cnt++; if (bus.a_ready !== 1'b1) $display("FAIL post_rst_a_ready: got %0h exp 1", bus.a_ready); else pass_cnt++;
        total_cnt++; if (bus.m_ready !== 1'b1) $display("FAIL post_rst_m_ready: got %0h exp 1", bus.m_ready); else pass_cnt++;
    endtask

    task automatic test_a_only();
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 64'hAA;
        tick();
        total_cnt++; if (bus.RegWr !== 1'b1) $display("FAIL a_only_regwr: got %0h exp 1", bus.RegWr); else pass_cnt++;
        total_cnt++; if (bus.RW !== 5'd5) $display("FAIL a_only_rw: got %0h exp 5", bus.RW); else pass_cnt++;
        total_cnt++; if (bus.BusW !== 64'hAA) $display("FAIL a_only_busw: got %0h exp aa", bus.BusW); else pass_cnt++;
        idle();
        tick();
        total_cnt++; if (bus.RegWr !== 1'b0) $display("FAIL a_only_idle_regwr: got %0h exp 0", bus.RegWr); else pass_cnt++;
    endtask

    task automatic test_m_bypass_x31();
        bus.m_valid = 1'b1; bus.m_rd = 5'd7; bus.m_data = 64'h1234;
        tick();
        total_cnt++; if (bus.RegWr !== 1'b1) $display("FAIL byp_regwr: got %0h exp 1", bus.RegWr); else pass_cnt++;
        total_cnt++; if (bus.RW !== 5'd7) $display("FAIL byp_rw: got %0h exp 7", bus.RW); else pass_cnt++;
        total_cnt++; if (bus.BusW !== 64'h1234) $display("FAIL byp_busw: got %0h exp 1234", bus.BusW); else pass_cnt++;
        total_cnt++; if (bus.pending !== 32'd0) $display("FAIL byp_pending: got %0h exp 0", bus.pending); else pass_cnt++;
        total_cnt++; if (bus.fifo_count !== 3'd0) $display("FAIL byp_count: got %0h exp 0", bus.fifo_count); else pass_cnt++;
        bus.m_rd = 5'd31; bus.m_data = 64'h5555;
        #1;
        total_cnt++; if (bus.m_ready !== 1'b1) $display("FAIL m31_ready: got %0h exp 1", bus.m_ready); else pass_cnt++;
        tick();
        total_cnt++; if (bus.RegWr !== 1'b0) $display("FAIL m31_regwr: got %0h exp 0", bus.RegWr); else pass_cnt++;
        total_cnt++; if (bus.fifo_count !== 3'd0) $display("FAIL m31_count: got %0h exp 0", bus.fifo_count); else pass_cnt++;
        // A to X31 alongside M: A is dropped, M takes the slot by bypass.
        bus.a_valid = 1'b1; bus.a_rd = 5'd31; bus.a_data = 64'hDEAD;
        bus.m_rd = 5'd9; bus.m_data = 64'h99;
        tick();
        total_cnt++; if (bus.RW !== 5'd9 || bus.RegWr !== 1'b1) $display("FAIL a31_free_slot: got we=%0h rw=%0h exp we=1 rw=9", bus.RegWr, bus.RW); else pass_cnt++;
        total_cnt++; if (bus.fifo_count !== 3'd0) $display("FAIL a31_count: got %0h exp 0", bus.fifo_count); else pass_cnt++;
        idle();
        tick();
    endtask

    task automatic test_conflict();
        bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 64'h11;
        bus.m_valid = 1'b1; bus.m_rd = 5'd2; bus.m_data = 64'h22;
        tick();
        total_cnt++; if (bus.RW !== 5'd1 || bus.BusW !== 64'h11) $display("FAIL cfl_a_write: got rw=%0h data=%0h exp rw=1 data=11", bus.RW, bus.BusW); else pass_cnt++;
        total_cnt++; if (bus.fifo_count !== 3'd1) $display("FAIL cfl_count: got %0h exp 1", bus.fifo_count); else pass_cnt++;
        total_cnt++; if (bus.pending !== 32'h4) $display("FAIL cfl_pending: got %0h exp 4", bus.pending); else pass_cnt++;
        idle();
        tick();
        total_cnt++; if (bus.RegWr !== 1'b1 || bus.RW !== 5'd2 || bus.BusW !== 64'h22) $display("FAIL cfl_drain: got we=%0h rw=%0h data=%0h exp we=1 rw=2 data=22", bus.RegWr, bus.RW, bus.BusW); else pass_cnt++;
        total_cnt++; if (bus.pending !== 32'd0) $display("FAIL cfl_drain_pending: got %0h exp 0", bus.pending); else pass_cnt++;
        total_cnt++; if (bus.fifo_count !== 3'd0) $display("FAIL cfl_drain_count: got %0h exp 0", bus.fifo_count); else pass_cnt++;
    endtask

    task automatic test_full_starve();
        int midx;
        logic       exp_ar, exp_mr;
        logic [2:0] exp_cnt;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            midx = (cyc <= 4) ? cyc - 1 : 4;
            bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 64'h200 + 64'(cyc);
            bus.m_valid = 1'b1; bus.m_rd = 5'(20 + midx); bus.m_data = 64'h100 + 64'(midx);
            exp_ar  = (cyc <= 9);
            exp_mr  = (cyc <= 4);
            exp_cnt = (cyc <= 4) ? 3'(cyc) : ((cyc <= 9) ? 3'd4 : 3'd3);
            #1;
            total_cnt++; if (bus.a_ready !== exp_ar) $display("FAIL full_a_ready c%0d: got %0h exp %0h", cyc, bus.a_ready, exp_ar); else pass_cnt++;
            total_cnt++; if (bus.m_ready !== exp_mr) $display("FAIL full_m_ready c%0d: got %0h exp %0h", cyc, bus.m_ready, exp_mr); else pass_cnt++;
            tick();
            total_cnt++; if (bus.fifo_count !== exp_cnt) $display("FAIL full_count c%0d: got %0h exp %0h", cyc, bus.fifo_count, exp_cnt); else pass_cnt++;
            if (cyc <= 9) begin
                total_cnt++; if (bus.RegWr !== 1'b1 || bus.RW !== 5'd10 || bus.BusW !== 64'h200 + 64'(cyc)) $display("FAIL full_a_write c%0d: got we=%0h rw=%0h data=%0h exp we=1 rw=a", cyc, bus.RegWr, bus.RW, bus.BusW); else pass_cnt++;
            end else begin
                total_cnt++; if (bus.RegWr !== 1'b1 || bus.RW !== 5'd20 || bus.BusW !== 64'h100) $display("FAIL full_head_pop: got we=%0h rw=%0h data=%0h exp we=1 rw=14 data=100", bus.RegWr, bus.RW, bus.BusW); else pass_cnt++;
            end
            if (cyc == 4) begin
                total_cnt++; if (bus.pending !== 32'h00F0_0000) $display("FAIL full_pending: got %0h exp f00000", bus.pending); else pass_cnt++;
            end
        end
        // A (held from the refused cycle) wins again; held M entry 4 enqueues.
        #1;
        total_cnt++; if (bus.a_ready !== 1'b1 || bus.m_ready !== 1'b1) $display("FAIL full_recover_ready: got a=%0h m=%0h exp 1 1", bus.a_ready, bus.m_ready); else pass_cnt++;
        tick();
        total_cnt++; if (bus.RW !== 5'd10 || bus.BusW !== 64'h20A) $display("FAIL full_recover_a: got rw=%0h data=%0h exp rw=a data=20a", bus.RW, bus.BusW); else pass_cnt++;
        total_cnt++; if (bus.pending !== 32'h01E0_0000) $display("FAIL full_recover_pending: got %0h exp 1e00000", bus.pending); else pass_cnt++;
        idle();
        for (int k = 1; k <= 4; k++) begin
            tick();
            total_cnt++; if (bus.RegWr !== 1'b1 || bus.RW !== 5'(20 + k) || bus.BusW !== 64'h100 + 64'(k)) $display("FAIL full_order m%0d: got we=%0h rw=%0h data=%0h", k, bus.RegWr, bus.RW, bus.BusW); else pass_cnt++;
        end
        total_cnt++; if (bus.fifo_count !== 3'd0 || bus.pending !== 32'd0) $display("FAIL full_empty: got cnt=%0h pend=%0h exp 0 0", bus.fifo_count, bus.pending); else pass_cnt++;
        tick();
        total_cnt++; if (bus.RegWr !== 1'b0) $display("FAIL full_idle_regwr: got %0h exp 0", bus.RegWr); else pass_cnt++;
    endtask

    task automatic test_wrap_pending();
        logic [4:0]  rds  [4] = '{5'd3, 5'd3, 5'd4, 5'd3};
        logic [31:0] pend [4] = '{32'h18, 32'h18, 32'h08, 32'h00};
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                bus.a_valid = 1'b1; bus.a_rd = 5'd12; bus.a_data = 64'h300 + 64'(k);
                bus.m_valid = 1'b1; bus.m_rd = rds[k]; bus.m_data = 64'h400 + 64'(r * 16 + k);
                tick();
                total_cnt++; if (bus.fifo_count !== 3'(k + 1) || bus.RW !== 5'd12) $display("FAIL wrap_fill r%0d k%0d: got cnt=%0h rw=%0h", r, k, bus.fifo_count, bus.RW); else pass_cnt++;
            end
            total_cnt++; if (bus.pending !== 32'h18) $display("FAIL wrap_full_pending r%0d: got %0h exp 18", r, bus.pending); else pass_cnt++;
            idle();
            for (int k = 0; k < 4; k++) begin
                tick();
                total_cnt++; if (bus.RegWr !== 1'b1 || bus.RW !== rds[k] || bus.BusW !== 64'h400 + 64'(r * 16 + k)) $display("FAIL wrap_drain r%0d k%0d: got we=%0h rw=%0h data=%0h", r, k, bus.RegWr, bus.RW, bus.BusW); else pass_cnt++;
                total_cnt++; if (bus.pending !== pend[k]) $display("FAIL wrap_pending r%0d k%0d: got %0h exp %0h", r, k, bus.pending, pend[k]); else pass_cnt++;
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            bus.a_valid = 1'b1; bus.a_rd = 5'd13; bus.a_data = 64'h500;
            bus.m_valid = 1'b1; bus.m_rd = 5'(15 + k); bus.m_data = 64'h600 + 64'(k);
            tick();
        end
        total_cnt++; if (bus.fifo_count !== 3'd3) $display("FAIL rmid_prefill: got %0h exp 3", bus.fifo_count); else pass_cnt++;
        resetl = 1'b0;
        #1;
        total_cnt++; if (bus.a_ready !== 1'b0 || bus.m_ready !== 1'b0) $display("FAIL rmid_ready: got a=%0h m=%0h exp 0 0", bus.a_ready, bus.m_ready); else pass_cnt++;
        tick();
        total_cnt++; if (bus.fifo_count !== 3'd0 || bus.pending !== 32'd0 || bus.RegWr !== 1'b0) $display("FAIL rmid_cleared: got cnt=%0h pend=%0h we=%0h exp 0 0 0", bus.fifo_count, bus.pending, bus.RegWr); else pass_cnt++;
        resetl = 1'b1;
        idle();
        bus.a_valid = 1'b1; bus.a_rd = 5'd6; bus.a_data = 64'h66;
        tick();
        total_cnt++; if (bus.RegWr !== 1'b1 || bus.RW !== 5'd6 || bus.BusW !== 64'h66) $display("FAIL rmid_fresh_a: got we=%0h rw=%0h data=%0h exp we=1 rw=6 data=66", bus.RegWr, bus.RW, bus.BusW); else pass_cnt++;
        idle();
        tick();
        total_cnt++; if (bus.RegWr !== 1'b0 || bus.fifo_count !== 3'd0) $display("FAIL rmid_discarded: got we=%0h cnt=%0h exp 0 0", bus.RegWr, bus.fifo_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_m_bypass_x31();
        test_conflict();
        test_full_starve();
        test_wrap_pending();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
`default_nettype wire
